// File: rtl/draw_menu_text_if.sv
// VGA timing bundle shared by the pixel pipeline stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_menu_text.sv
// Navigable multi-line 8x16 text overlay with a blinking highlighted line.
// Glyph ROM has one clock of read latency; unknown codes render blank.
module font_rom (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  output logic [7:0]  char_line_pixels
);
  logic [127:0] glyph;
  logic [127:0] shifted;

  always_comb begin
    case (addr[10:4])
      7'h41:   glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h42:   glyph = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
      7'h43:   glyph = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
      7'h44:   glyph = 128'h0000_F86C_6666_6666_6666_6CF8_0000_0000;
      7'h45:   glyph = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
      7'h7F:   glyph = '1;
      default: glyph = '0;
    endcase
    // Row 0 sits in the top byte.
    shifted = glyph << {addr[3:0], 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_line_pixels <= '0;
    else     char_line_pixels <= shifted[127:120];
  end
endmodule

module draw_menu_text #(
  parameter int          X             = 0,
  parameter int          Y             = 0,
  parameter int          N_LINES       = 5,
  parameter int          CHARS_IN_LINE = 16,
  parameter int          LINE_PITCH    = 24,
  parameter logic [11:0] FONT_COLOR    = 12'h000,
  parameter logic [11:0] SEL_COLOR     = 12'hF00,
  parameter int          BLINK_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic [11:0] rgb_i,
  vga_if.out          vga_out,
  output logic [11:0] rgb_o,
  input  logic        up,
  input  logic        down,
  output logic [3:0]  sel_o,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code
);
  localparam logic [11:0] X_LO  = 12'(X);
  localparam logic [11:0] X_HI  = 12'(X + 8 * CHARS_IN_LINE);
  localparam logic [11:0] Y_LO  = 12'(Y);
  localparam logic [11:0] Y_HI  = 12'(Y + LINE_PITCH * N_LINES);
  localparam logic [10:0] PITCH = 11'(LINE_PITCH);
  localparam logic [3:0]  LAST  = 4'(N_LINES - 1);
  localparam int          CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  timing_t     t0, t1, t2, t3;
  logic [11:0] rgb1, rgb2, rgb3;
  logic        hit0, hit1, hit2, hit3;
  logic [2:0]  off1, off2, off3;
  logic [3:0]  row1, row2;
  logic [3:0]  line1, line2, line3;
  logic [10:0] dx, dy, row_full;
  logic [7:0]  char_pixels;

  logic        vs_prev, vs_rise, sel_step;
  logic [3:0]  sel, drawn_sel;
  logic [CW-1:0] cnt;
  logic        blink_on, restart;
  logic [11:0] colour;
  logic        lit;

  assign t0 = {vga_in.hcount, vga_in.vcount, vga_in.hsync,
               vga_in.vsync, vga_in.hblnk, vga_in.vblnk};

  // Offsets may wrap outside the area, but hit0 masks them off.
  always_comb begin
    dx       = vga_in.hcount - X_LO[10:0];
    dy       = vga_in.vcount - Y_LO[10:0];
    row_full = dy % PITCH;
    hit0     = ({1'b0, vga_in.hcount} >= X_LO) && ({1'b0, vga_in.hcount} < X_HI) &&
               ({1'b0, vga_in.vcount} >= Y_LO) && ({1'b0, vga_in.vcount} < Y_HI) &&
               (row_full < 11'd16) && !vga_in.hblnk && !vga_in.vblnk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1 <= '0; t2 <= '0; t3 <= '0;
      rgb1 <= '0; rgb2 <= '0; rgb3 <= '0;
      hit1 <= 1'b0; hit2 <= 1'b0; hit3 <= 1'b0;
      off1 <= '0; off2 <= '0; off3 <= '0;
      row1 <= '0; row2 <= '0;
      line1 <= '0; line2 <= '0; line3 <= '0;
      char_xy <= '0;
    end else begin
      t1 <= t0; rgb1 <= rgb_i; hit1 <= hit0;
      off1 <= dx[2:0]; row1 <= row_full[3:0]; line1 <= 4'(dy / PITCH);
      if (hit0) char_xy <= {4'(dy / PITCH), dx[6:3]};

      t2 <= t1; rgb2 <= rgb1; hit2 <= hit1;
      off2 <= off1; row2 <= row1; line2 <= line1;

      t3 <= t2; rgb3 <= rgb2; hit3 <= hit2;
      off3 <= off2; line3 <= line2;
    end
  end

  font_rom u_font_rom (
    .clk              (clk),
    .rst              (rst),
    .addr             ({char_code, row2}),
    .char_line_pixels (char_pixels)
  );

  always_comb begin
    colour = (line3 == drawn_sel && blink_on) ? SEL_COLOR : FONT_COLOR;
    lit    = hit3 && char_pixels[3'd7 - off3];
    rgb_o  = lit ? colour : rgb3;
  end

  assign vga_out.hcount = t3.hcount;
  assign vga_out.vcount = t3.vcount;
  assign vga_out.hsync  = t3.hsync;
  assign vga_out.vsync  = t3.vsync;
  assign vga_out.hblnk  = t3.hblnk;
  assign vga_out.vblnk  = t3.vblnk;

  assign vs_rise  = vga_in.vsync && !vs_prev;
  assign sel_step = (up ^ down) && (N_LINES > 1);
  assign sel_o    = sel;

  // A selection change is latched and applied at the next frame start so
  // the freshly drawn line always begins in the highlighted phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev   <= 1'b0;
      sel       <= '0;
      drawn_sel <= '0;
      cnt       <= '0;
      blink_on  <= 1'b1;
      restart   <= 1'b0;
    end else begin
      vs_prev <= vga_in.vsync;
      if (up && !down)      sel <= (sel == '0)   ? LAST : sel - 1'b1;
      else if (down && !up) sel <= (sel == LAST) ? '0   : sel + 1'b1;

      if (vs_rise) begin
        drawn_sel <= sel;
        restart   <= 1'b0;
        if (restart) begin
          cnt      <= '0;
          blink_on <= 1'b1;
        end else if (BLINK_FRAMES > 0) begin
          if (cnt == CW'(BLINK_FRAMES - 1)) begin
            cnt      <= '0;
            blink_on <= ~blink_on;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
      if (sel_step) restart <= 1'b1;
    end
  end
endmodule
